// File: rtl/l2_sync_response.sv
// Registers one completed L2 operation per cycle into the response packet.
// Define L2_SYNC_RESERVATION_EN to enable the per-(core,strand) reservation table for synchronized load/store.

package l2_sync_response_pkg;
    localparam int L2RSP_OP_WIDTH     = 2;
    localparam int STRANDS_PER_CORE   = 4;
    localparam int STRAND_INDEX_WIDTH = 2;
    localparam int UNIT_ID_WIDTH      = 3;
    localparam int L1_WAY_INDEX_WIDTH = 2;
    localparam int L2_ADDR_WIDTH      = 26;
    localparam int CACHE_LINE_BITS    = 512;

    typedef logic [UNIT_ID_WIDTH-1:0] unit_id_t;

    typedef enum logic [L2RSP_OP_WIDTH-1:0] {
        L2RSP_LOAD_ACK    = 2'd0,
        L2RSP_STORE_ACK   = 2'd1,
        L2RSP_DINVALIDATE = 2'd2,
        L2RSP_IINVALIDATE = 2'd3
    } l2rsp_op_t;
endpackage

module l2_sync_response
    import l2_sync_response_pkg::*;
#(
    parameter int NUM_CORES = 1,
    localparam int CORE_ID_WIDTH = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
    localparam int PACKET_BITS = 2 + CORE_ID_WIDTH + UNIT_ID_WIDTH + STRAND_INDEX_WIDTH
                               + L2RSP_OP_WIDTH + NUM_CORES + L1_WAY_INDEX_WIDTH * NUM_CORES
                               + L2_ADDR_WIDTH + CACHE_LINE_BITS
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    rsp_valid_i,
    input  logic [L2RSP_OP_WIDTH-1:0]               rsp_op_i,
    input  logic [CORE_ID_WIDTH-1:0]                rsp_core_i,
    input  logic [UNIT_ID_WIDTH-1:0]                rsp_unit_i,
    input  logic [STRAND_INDEX_WIDTH-1:0]           rsp_strand_i,
    input  logic                                    rsp_synchronized_i,
    input  logic [L2_ADDR_WIDTH-1:0]                rsp_address_i,
    input  logic [CACHE_LINE_BITS-1:0]              rsp_data_i,
    input  logic [L1_WAY_INDEX_WIDTH*NUM_CORES-1:0] rsp_way_i,
    input  logic [NUM_CORES-1:0]                    rsp_update_i,
    output logic [PACKET_BITS-1:0]                  l2rsp_packet,
    output logic                                    pc_event_sync_fail
);

    // Field order (MSB first) is the packet layout seen by consumers.
    typedef struct packed {
        logic                                    valid;
        logic                                    status;
        logic [CORE_ID_WIDTH-1:0]                core;
        unit_id_t                                unit;
        logic [STRAND_INDEX_WIDTH-1:0]           strand;
        logic [L2RSP_OP_WIDTH-1:0]               op;
        logic [NUM_CORES-1:0]                    update;
        logic [L1_WAY_INDEX_WIDTH*NUM_CORES-1:0] way;
        logic [L2_ADDR_WIDTH-1:0]                address;
        logic [CACHE_LINE_BITS-1:0]              data;
    } l2rsp_packet_t;

    l2rsp_packet_t        pkt;
    logic                 status;
    logic                 sync_fail;
    logic [NUM_CORES-1:0] update_out;

`ifdef L2_SYNC_RESERVATION_EN
    localparam int ENTRIES   = NUM_CORES * STRANDS_PER_CORE;
    localparam int IDX_WIDTH = CORE_ID_WIDTH + STRAND_INDEX_WIDTH;

    logic [ENTRIES-1:0]       res_valid;
    logic [ENTRIES-1:0]       res_valid_nxt;
    logic [ENTRIES-1:0]       own_sel;
    logic [ENTRIES-1:0]       addr_match;
    logic [L2_ADDR_WIDTH-1:0] res_addr [ENTRIES];
    logic [IDX_WIDTH-1:0]     own_idx;
    logic                     is_load;
    logic                     is_store;
    logic                     own_hit;
    logic                     set_own;
    logic                     store_ok;

    assign own_idx = {rsp_core_i, rsp_strand_i};

    always_comb begin
        own_sel    = '0;
        addr_match = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            own_sel[i]    = (IDX_WIDTH'(i) == own_idx);
            addr_match[i] = res_valid[i] && (res_addr[i] == rsp_address_i);
        end
    end

    // Status is decided from the table as it stood before this edge.
    always_comb begin
        is_load   = rsp_valid_i && (rsp_op_i == L2RSP_LOAD_ACK);
        is_store  = rsp_valid_i && (rsp_op_i == L2RSP_STORE_ACK);
        own_hit   = |(own_sel & addr_match);
        set_own   = is_load && rsp_synchronized_i;
        sync_fail = is_store && rsp_synchronized_i && !own_hit;
        store_ok  = is_store && !sync_fail;
        status    = !sync_fail;

        res_valid_nxt = res_valid;
        if (store_ok)
            res_valid_nxt = res_valid_nxt & ~addr_match;
        if (is_store && rsp_synchronized_i)
            res_valid_nxt = res_valid_nxt & ~own_sel;
        if (set_own)
            res_valid_nxt = res_valid_nxt | own_sel;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++)
                res_addr[i] <= '0;
        end else begin
            res_valid <= res_valid_nxt;
            for (int unsigned i = 0; i < ENTRIES; i++)
                if (set_own && own_sel[i])
                    res_addr[i] <= rsp_address_i;
        end
    end
`else
    logic sync_unused;

    assign sync_unused = rsp_synchronized_i;
    assign status      = 1'b1;
    assign sync_fail   = 1'b0;
`endif

    assign update_out = sync_fail ? '0 : rsp_update_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt                <= '0;
            pc_event_sync_fail <= 1'b0;
        end else begin
            pkt.valid          <= rsp_valid_i;
            pc_event_sync_fail <= rsp_valid_i && sync_fail;
            if (rsp_valid_i) begin
                pkt.status  <= status;
                pkt.core    <= rsp_core_i;
                pkt.unit    <= rsp_unit_i;
                pkt.strand  <= rsp_strand_i;
                pkt.op      <= rsp_op_i;
                pkt.update  <= update_out;
                pkt.way     <= rsp_way_i;
                pkt.address <= rsp_address_i;
                pkt.data    <= rsp_data_i;
            end
        end
    end

    assign l2rsp_packet = pkt;

endmodule

// File: tb/tb_l2_sync_response.sv
// Directed bench for l2_sync_response (two cores); expected status depends on L2_SYNC_RESERVATION_EN.

module tb_l2_sync_response;
    import l2_sync_response_pkg::*;

    localparam int NC = 2;
`ifdef L2_SYNC_RESERVATION_EN
    localparam bit RES_EN = 1'b1;
`else
    localparam bit RES_EN = 1'b0;
`endif

    typedef struct packed {
        logic                             valid;
        logic                             status;
        logic [0:0]                       core;
        logic [UNIT_ID_WIDTH-1:0]         unit;
        logic [STRAND_INDEX_WIDTH-1:0]    strand;
        logic [L2RSP_OP_WIDTH-1:0]        op;
        logic [NC-1:0]                    update;
        logic [L1_WAY_INDEX_WIDTH*NC-1:0] way;
        logic [L2_ADDR_WIDTH-1:0]         address;
        logic [CACHE_LINE_BITS-1:0]       data;
    } pkt_t;

    logic                             clk = 1'b0;
    logic                             reset = 1'b1;
    logic                             rsp_valid_i = 1'b0;
    logic [L2RSP_OP_WIDTH-1:0]        rsp_op_i = '0;
    logic [0:0]                       rsp_core_i = '0;
    logic [UNIT_ID_WIDTH-1:0]         rsp_unit_i = '0;
    logic [STRAND_INDEX_WIDTH-1:0]    rsp_strand_i = '0;
    logic                             rsp_synchronized_i = 1'b0;
    logic [L2_ADDR_WIDTH-1:0]         rsp_address_i = '0;
    logic [CACHE_LINE_BITS-1:0]       rsp_data_i = '0;
    logic [L1_WAY_INDEX_WIDTH*NC-1:0] rsp_way_i = '0;
    logic [NC-1:0]                    rsp_update_i = '0;
    pkt_t                             pkt;
    logic                             sync_fail_o;

    pkt_t        exp_pkt = '0;
    logic        exp_fail = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int unsigned seq = 0;

    l2_sync_response #(.NUM_CORES(NC)) dut (
        .clk                (clk),
        .reset              (reset),
        .rsp_valid_i        (rsp_valid_i),
        .rsp_op_i           (rsp_op_i),
        .rsp_core_i         (rsp_core_i),
        .rsp_unit_i         (rsp_unit_i),
        .rsp_strand_i       (rsp_strand_i),
        .rsp_synchronized_i (rsp_synchronized_i),
        .rsp_address_i      (rsp_address_i),
        .rsp_data_i         (rsp_data_i),
        .rsp_way_i          (rsp_way_i),
        .rsp_update_i       (rsp_update_i),
        .l2rsp_packet       (pkt),
        .pc_event_sync_fail (sync_fail_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag);
        chk({tag, ":valid"},  640'(pkt.valid),   640'(exp_pkt.valid));
        chk({tag, ":status"}, 640'(pkt.status),  640'(exp_pkt.status));
        chk({tag, ":update"}, 640'(pkt.update),  640'(exp_pkt.update));
        chk({tag, ":fail"},   640'(sync_fail_o), 640'(exp_fail));
        chk({tag, ":packet"}, 640'(pkt),         640'(exp_pkt));
    endtask

    // res_status is the hand-derived status when reservations are enabled.
    task automatic step(input string tag, input l2rsp_op_t op, input logic core,
                        input logic [1:0] strand, input logic sync,
                        input logic [25:0] addr, input logic res_status);
        logic fail;
        seq++;
        rsp_valid_i        = 1'b1;
        rsp_op_i           = op;
        rsp_core_i         = core;
        rsp_strand_i       = strand;
        rsp_synchronized_i = sync;
        rsp_address_i      = addr;
        rsp_unit_i         = 3'(seq);
        rsp_way_i          = 4'(seq * 3);
        rsp_update_i       = 2'(seq) | 2'b01;
        for (int i = 0; i < 16; i++)
            rsp_data_i[i*32 +: 32] = $urandom;
        fail = RES_EN && sync && (op == L2RSP_STORE_ACK) && !res_status;
        exp_pkt = '{valid: 1'b1, status: RES_EN ? res_status : 1'b1, core: core,
                    unit: rsp_unit_i, strand: strand, op: op,
                    update: fail ? 2'b00 : rsp_update_i, way: rsp_way_i,
                    address: addr, data: rsp_data_i};
        exp_fail = fail;
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    task automatic idle(input string tag);
        rsp_valid_i        = 1'b0;
        rsp_op_i           = L2RSP_STORE_ACK;
        rsp_synchronized_i = 1'b1;
        rsp_address_i      = 26'h3ff_ffff;
        rsp_data_i         = '1;
        rsp_update_i       = '1;
        exp_pkt.valid      = 1'b0;
        exp_fail           = 1'b0;
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    initial begin
        #12;
        check_out("reset_state");
        @(posedge clk);
        #1;
        reset = 1'b0;

        step("r28_load",      L2RSP_LOAD_ACK,  1'b0, 2'd2, 1'b1, 26'h0000400, 1'b1);
        step("r28_store",     L2RSP_STORE_ACK, 1'b0, 2'd2, 1'b1, 26'h0000400, 1'b1);

        step("r29_load",      L2RSP_LOAD_ACK,  1'b0, 2'd2, 1'b1, 26'h0000400, 1'b1);
        step("r29_plain_st",  L2RSP_STORE_ACK, 1'b0, 2'd1, 1'b0, 26'h0000400, 1'b1);
        step("r29_sync_st",   L2RSP_STORE_ACK, 1'b0, 2'd2, 1'b1, 26'h0000400, 1'b0);

        step("r30_st_a",      L2RSP_STORE_ACK, 1'b0, 2'd0, 1'b1, 26'h0000800, 1'b0);
        step("r30_st_b",      L2RSP_STORE_ACK, 1'b0, 2'd0, 1'b1, 26'h0000800, 1'b0);

        step("r31_ld10",      L2RSP_LOAD_ACK,  1'b0, 2'd0, 1'b1, 26'h0000010, 1'b1);
        step("r31_ld20",      L2RSP_LOAD_ACK,  1'b0, 2'd0, 1'b1, 26'h0000020, 1'b1);
        step("r31_st10",      L2RSP_STORE_ACK, 1'b0, 2'd0, 1'b1, 26'h0000010, 1'b0);
        step("r31_reld20",    L2RSP_LOAD_ACK,  1'b0, 2'd0, 1'b1, 26'h0000020, 1'b1);
        step("r31_st20",      L2RSP_STORE_ACK, 1'b0, 2'd0, 1'b1, 26'h0000020, 1'b1);

        idle("idle_hold_a");
        idle("idle_hold_b");

        step("xc_ld_c1s3",    L2RSP_LOAD_ACK,  1'b1, 2'd3, 1'b1, 26'h0000055, 1'b1);
        step("xc_ld_c0s0",    L2RSP_LOAD_ACK,  1'b0, 2'd0, 1'b1, 26'h0000055, 1'b1);
        step("xc_st_c0s0",    L2RSP_STORE_ACK, 1'b0, 2'd0, 1'b1, 26'h0000055, 1'b1);
        step("xc_st_c1s3",    L2RSP_STORE_ACK, 1'b1, 2'd3, 1'b1, 26'h0000055, 1'b0);

        step("inv_ld",        L2RSP_LOAD_ACK,    1'b1, 2'd0, 1'b1, 26'h0000066, 1'b1);
        step("inv_d",         L2RSP_DINVALIDATE, 1'b0, 2'd1, 1'b0, 26'h0000066, 1'b1);
        step("inv_i",         L2RSP_IINVALIDATE, 1'b0, 2'd1, 1'b0, 26'h0000066, 1'b1);
        step("inv_st",        L2RSP_STORE_ACK,   1'b1, 2'd0, 1'b1, 26'h0000066, 1'b1);

        step("nc_ld_s1",      L2RSP_LOAD_ACK,  1'b0, 2'd1, 1'b1, 26'h0000077, 1'b1);
        step("nc_badst_s3",   L2RSP_STORE_ACK, 1'b0, 2'd3, 1'b1, 26'h0000077, 1'b0);
        step("nc_st_s1",      L2RSP_STORE_ACK, 1'b0, 2'd1, 1'b1, 26'h0000077, 1'b1);

        step("r33_ld40",      L2RSP_LOAD_ACK,  1'b0, 2'd0, 1'b1, 26'h0000040, 1'b1);
        rsp_valid_i        = 1'b1;
        rsp_op_i           = L2RSP_STORE_ACK;
        rsp_synchronized_i = 1'b0;
        rsp_address_i      = 26'h0000099;
        reset              = 1'b1;
        exp_pkt            = '0;
        exp_fail           = 1'b0;
        #2;
        check_out("r33_in_reset");
        @(posedge clk);
        #1;
        check_out("r33_reset_edge");
        reset = 1'b0;
        step("r33_st40",      L2RSP_STORE_ACK, 1'b0, 2'd0, 1'b1, 26'h0000040, 1'b0);
        idle("final_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/l2_sync_response.md
L2_SYNC_RESPONSE -- requirements
Module: l2_sync_response

Interface
REQ-001 Parameter NUM_CORES, default 1, number of cores sharing the L2 response bus.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 rsp_valid_i  input  1  completed L2 pipeline operation present this cycle.
REQ-005 rsp_op_i  input  l2rsp op width  L2RSP_LOAD_ACK, L2RSP_STORE_ACK, L2RSP_DINVALIDATE or L2RSP_IINVALIDATE.
REQ-006 rsp_core_i / rsp_unit_i / rsp_strand_i  input  core-id / unit_id_t / STRAND_INDEX_WIDTH  requester identity.
REQ-007 rsp_synchronized_i  input  1  request was a synchronized load or store.
REQ-008 rsp_address_i  input  26  line address; rsp_data_i  input  CACHE_LINE_BITS  line data.
REQ-009 rsp_way_i  input  L1_WAY_INDEX_WIDTH*NUM_CORES  per-core L1 destination way.
REQ-010 rsp_update_i  input  NUM_CORES  cores whose L1 holds the line.
REQ-011 l2rsp_packet  output  l2rsp_packet_t  fields: valid, status, core, unit, strand, op, update, way, address, data.
REQ-012 pc_event_sync_fail  output  1  one-cycle pulse per failed synchronized store.

Function
REQ-013 Latency fixed at one cycle: every input field is registered into l2rsp_packet on the next edge; no backpressure, no input dropped.
REQ-014 l2rsp_packet.valid equals rsp_valid_i delayed one cycle; all other fields hold their last value when valid is 0.
REQ-015 Reservation table: one entry per (core, strand), NUM_CORES*STRANDS_PER_CORE entries, each valid bit plus 26-bit address.
REQ-016 Synchronized LOAD_ACK: entry of (rsp_core_i, rsp_strand_i) set valid with rsp_address_i, overwriting any existing entry; status=1.
REQ-017 Synchronized STORE_ACK: status=1 iff own entry valid and its address equals rsp_address_i; own entry cleared in either case.
REQ-018 Successful store (non-synchronized, or synchronized with status=1) to address A clears every valid entry whose address equals A, all cores and strands, same edge.
REQ-019 Failed synchronized store: status=0, update field forced to all-zeros, no other entry cleared, pc_event_sync_fail=1 for that output cycle.
REQ-020 Non-store, non-synchronized ops: status=1, reservations untouched; DINVALIDATE and IINVALIDATE do not affect reservations.
REQ-021 Status evaluation uses table contents before the current cycle's update (read-before-write); set and clear effects visible to the next input.
REQ-022 Synchronized LOAD_ACK on a line that a concurrent-cycle store cannot touch (one input per cycle), so no same-cycle set/clear conflict exists.
REQ-023 way, core, unit, strand, op, address, data pass through unmodified.

Reset
REQ-024 On reset: l2rsp_packet.valid=0, status=0, remaining packet fields 0, pc_event_sync_fail=0, all reservation valid bits 0.
REQ-025 Reset asserted mid-stream discards the registered response; first input after deassertion behaves as after power-up.

Configuration
REQ-026 Macro L2_SYNC_RESERVATION_EN: when defined, REQ-015..REQ-021 apply.
REQ-027 When L2_SYNC_RESERVATION_EN is undefined: no reservation table is instantiated, every response has status=1, update passes through unmodified, pc_event_sync_fail tied 0.

Verification
REQ-028 Core 0 strand 2 sync load 0x0000400, then sync store 0x0000400 -> response status=1, update=rsp_update_i, no fail pulse.
REQ-029 Strand 2 sync load 0x0000400, strand 1 plain store 0x0000400, strand 2 sync store 0x0000400 -> last response status=0, update=0, pc_event_sync_fail=1 one cycle.
REQ-030 Sync store 0x0000800 with no prior sync load -> status=0; immediately repeated sync store -> status=0.
REQ-031 Strand 0 sync load 0x10, strand 0 sync load 0x20, sync store 0x10 -> status=0; sync store 0x20 after re-reserving 0x20 -> status=1.
REQ-032 Back-to-back valid inputs for 8 cycles with mixed ops -> 8 consecutive output packets, each one cycle later, fields identical to inputs except status/update per rules.
REQ-033 Sync load 0x40, assert reset one cycle mid-stream, then sync store 0x40 -> output valid=0 during reset, store response status=0.
